// File: rtl/sdram_port_arbiter_pkg.sv
// Shared types for the SDRAM port arbiter: FSM states, command owner, default address width.
package gnw_sdram_arb_pkg;

    localparam int SDRAM_ADDR_W = 25;

    typedef enum logic [2:0] {
        SYNC,
        IDLE,
        ISSUE,
        GUARD,
        WAIT,
        DONE
    } arb_state_t;

    typedef enum logic {
        OWN_WR,
        OWN_RD
    } owner_t;

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Loader, renderer and controller signals of the arbiter; slave = arbiter side, master = surroundings.
// Perf counter outputs exist only when SDRAM_ARB_PERF_EN is defined.
interface sdram_port_arbiter_if
    import gnw_sdram_arb_pkg::*;
#(
    parameter int ADDR_W = SDRAM_ADDR_W
) ();

    logic              dl_active;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              wr_ack;
    logic              wr_wait;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] img_base;
    logic [7:0]        rd_data;
    logic              rd_valid;
    logic [ADDR_W-1:0] sd_addr;
    logic [7:0]        sd_din;
    logic              sd_rd;
    logic              sd_we;
    logic [7:0]        sd_dout;
    logic              sd_ready;
    logic              timeout_err;
`ifdef SDRAM_ARB_PERF_EN
    logic [31:0]       perf_rd_cnt;
    logic [31:0]       perf_stall_cnt;
`endif

    modport slave (
        input  dl_active, wr_req, wr_addr, wr_data, rd_req, rd_addr, img_base, sd_dout, sd_ready,
        output wr_ack, wr_wait, rd_data, rd_valid, sd_addr, sd_din, sd_rd, sd_we, timeout_err
`ifdef SDRAM_ARB_PERF_EN
        , output perf_rd_cnt, perf_stall_cnt
`endif
    );

    modport master (
        output dl_active, wr_req, wr_addr, wr_data, rd_req, rd_addr, img_base, sd_dout, sd_ready,
        input  wr_ack, wr_wait, rd_data, rd_valid, sd_addr, sd_din, sd_rd, sd_we, timeout_err
`ifdef SDRAM_ARB_PERF_EN
        , input perf_rd_cnt, perf_stall_cnt
`endif
    );

endinterface

// File: rtl/sdram_port_arbiter_perf.sv
// Saturating completed-read and read-stall counters; one-cycle update, no backpressure.
module sdram_arb_perf (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        rd_done,
    input  logic        rd_stall,
    output logic [31:0] perf_rd_cnt,
    output logic [31:0] perf_stall_cnt
);

    logic [31:0] rd_cnt_q, rd_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        rd_cnt_d    = rd_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (rd_done && (rd_cnt_q != '1)) begin
            rd_cnt_d = rd_cnt_q + 32'd1;
        end
        if (rd_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            rd_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            rd_cnt_q    <= rd_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_rd_cnt    = rd_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;

endmodule

// File: rtl/sdram_port_arbiter.sv
// Serialises loader writes and renderer reads onto one 8-bit SDRAM port; 6 cycles request-to-ack minimum.
// Loader is held off through wr_wait while its single buffer is full; SDRAM_ARB_PERF_EN adds perf counters.
module sdram_port_arbiter
    import gnw_sdram_arb_pkg::*;
#(
    parameter int ADDR_W      = SDRAM_ADDR_W,
    parameter int GUARD_CYC   = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input logic                 clk_sys,
    input logic                 reset,
    sdram_port_arbiter_if.slave bus
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    arb_state_t        state_q, state_d;
    owner_t            owner_q, owner_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        din_q, din_d;
    logic [7:0]        rd_data_q, rd_data_d;
    logic              terr_q, terr_d;
    logic              buf_vld_q, buf_vld_d;
    logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
    logic [7:0]        buf_data_q, buf_data_d;
    logic              rd_pend_q, rd_pend_d;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        din_d      = din_q;
        rd_data_d  = rd_data_q;
        terr_d     = terr_q;
        buf_vld_d  = buf_vld_q;
        buf_addr_d = buf_addr_q;
        buf_data_d = buf_data_q;
        rd_pend_d  = bus.rd_req;

        case (state_q)
            SYNC: begin
                if (bus.sd_ready) state_d = IDLE;
            end
            IDLE: begin
                if (buf_vld_q) begin
                    owner_d = OWN_WR;
                    addr_d  = buf_addr_q;
                    din_d   = buf_data_q;
                    cnt_d   = '0;
                    state_d = ISSUE;
                end else if (rd_pend_q && !bus.dl_active) begin
                    owner_d = OWN_RD;
                    addr_d  = bus.img_base + bus.rd_addr;
                    din_d   = '0;
                    cnt_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = GUARD;
            end
            GUARD: begin
                // Controller may still show ready from before the command; don't trust it yet.
                cnt_d = cnt_q + 1'b1;
                if (cnt_q >= CNT_W'(GUARD_CYC)) state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (bus.sd_ready || (cnt_q >= CNT_W'(TIMEOUT_CYC))) begin
                    state_d = DONE;
                    if (!bus.sd_ready) terr_d = 1'b1;
                    if (owner_q == OWN_RD) rd_data_d = bus.sd_dout;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (owner_q == OWN_WR) buf_vld_d = 1'b0;
                else                   rd_pend_d = 1'b0;
            end
            default: state_d = SYNC;
        endcase

        // A new loader byte always lands in the buffer, even over an unserved one.
        if (bus.wr_req) begin
            buf_vld_d  = 1'b1;
            buf_addr_d = bus.wr_addr;
            buf_data_d = bus.wr_data;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q    <= SYNC;
            owner_q    <= OWN_WR;
            cnt_q      <= '0;
            addr_q     <= '0;
            din_q      <= '0;
            rd_data_q  <= '0;
            terr_q     <= 1'b0;
            buf_vld_q  <= 1'b0;
            buf_addr_q <= '0;
            buf_data_q <= '0;
            rd_pend_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            rd_data_q  <= rd_data_d;
            terr_q     <= terr_d;
            buf_vld_q  <= buf_vld_d;
            buf_addr_q <= buf_addr_d;
            buf_data_q <= buf_data_d;
            rd_pend_q  <= rd_pend_d;
        end
    end

    assign bus.sd_rd       = (state_q == ISSUE) && (owner_q == OWN_RD);
    assign bus.sd_we       = (state_q == ISSUE) && (owner_q == OWN_WR);
    assign bus.wr_ack      = (state_q == DONE) && (owner_q == OWN_WR);
    assign bus.rd_valid    = (state_q == DONE) && (owner_q == OWN_RD);
    assign bus.wr_wait     = buf_vld_q;
    assign bus.sd_addr     = addr_q;
    assign bus.sd_din      = din_q;
    assign bus.rd_data     = rd_data_q;
    assign bus.timeout_err = terr_q;

`ifdef SDRAM_ARB_PERF_EN
    logic rd_granted;
    assign rd_granted = (owner_q == OWN_RD) && (state_q inside {ISSUE, GUARD, WAIT, DONE});

    sdram_arb_perf u_perf (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .rd_done        (bus.rd_valid),
        .rd_stall       (bus.rd_req && !rd_granted),
        .perf_rd_cnt    (bus.perf_rd_cnt),
        .perf_stall_cnt (bus.perf_stall_cnt)
    );
`else
    // Counters absent in this build.
`endif

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter with a busy-cycle SDRAM ready model.
module tb_sdram_port_arbiter;
    import gnw_sdram_arb_pkg::*;

    logic clk;
    logic rst;

    sdram_port_arbiter_if bus ();

    sdram_port_arbiter dut (
        .clk_sys (clk),
        .reset   (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // SDRAM ready model, updated just after each rising edge.
    bit       model_stuck = 1'b1;
    int       model_busy  = 3;
    logic [7:0] model_dout = 8'h00;
    int       busy_left   = 0;

    always @(posedge clk) begin
        #1;
        if (model_stuck) begin
            bus.sd_ready = 1'b0;
            bus.sd_dout  = model_dout;
            busy_left    = 0;
        end else if (bus.sd_rd || bus.sd_we) begin
            if (model_busy == 0) begin
                bus.sd_ready = 1'b1;
                bus.sd_dout  = model_dout;
            end else begin
                bus.sd_ready = 1'b0;
                bus.sd_dout  = 8'hEE;
                busy_left    = model_busy;
            end
        end else if (busy_left > 0) begin
            busy_left = busy_left - 1;
            if (busy_left == 0) begin
                bus.sd_ready = 1'b1;
                bus.sd_dout  = model_dout;
            end
        end else begin
            bus.sd_ready = 1'b1;
        end
    end

    typedef struct {
        bit          is_wr;
        logic [24:0] addr;
        logic [24:0] base;
        logic [7:0]  data;
        int          busy;
        logic [24:0] exp_addr;
        logic [7:0]  exp_data;
        int          exp_lat;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, " strobes"}, 64'({bus.sd_rd, bus.sd_we, bus.wr_ack, bus.wr_wait,
                                  bus.rd_valid, bus.timeout_err}), 64'd0);
        chk({nm, " sd_addr"}, 64'(bus.sd_addr), 64'd0);
        chk({nm, " data"}, 64'({bus.rd_data, bus.sd_din}), 64'd0);
    endtask

    // One transaction from request to ack/valid; latency counted from the request cycle.
    task automatic do_txn(input string nm, input vec_t v);
        int cyc = 0;
        int n_right = 0;
        int n_wrong = 0;
        bit done = 1'b0;
        logic [24:0] seen_addr = '0;
        logic [7:0]  seen_data = '0;
        @(negedge clk);
        model_busy = v.busy;
        model_dout = v.data;
        if (v.is_wr) begin
            bus.wr_req  = 1'b1;
            bus.wr_addr = v.addr;
            bus.wr_data = v.data;
        end else begin
            bus.rd_req   = 1'b1;
            bus.rd_addr  = v.addr;
            bus.img_base = v.base;
        end
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            bus.wr_req = 1'b0;
            if (cyc == 1 && v.is_wr) chk({nm, " wr_wait set"}, 64'(bus.wr_wait), 64'd1);
            if ((v.is_wr && bus.sd_we) || (!v.is_wr && bus.sd_rd)) begin
                n_right++;
                seen_addr = bus.sd_addr;
                if (v.is_wr) seen_data = bus.sd_din;
            end
            if ((v.is_wr && bus.sd_rd) || (!v.is_wr && bus.sd_we)) n_wrong++;
            if (v.is_wr ? bus.wr_ack : bus.rd_valid) begin
                done = 1'b1;
                if (!v.is_wr) seen_data = bus.rd_data;
            end
        end
        bus.rd_req = 1'b0;
        chk({nm, " done"}, 64'(done), 64'd1);
        chk({nm, " latency"}, 64'(cyc), 64'(v.exp_lat));
        chk({nm, " cmd count"}, 64'(n_right * 16 + n_wrong), 64'd16);
        chk({nm, " sd_addr"}, 64'(seen_addr), 64'(v.exp_addr));
        chk({nm, " data"}, 64'(seen_data), 64'(v.exp_data));
        @(negedge clk);
        if (v.is_wr) chk({nm, " wr_wait clear"}, 64'(bus.wr_wait), 64'd0);
        else         chk({nm, " rd_data hold"}, 64'(bus.rd_data), 64'(v.exp_data));
    endtask

    // Read issued while the arbiter sits in SYNC with sd_ready held low for 'hold' cycles.
    task automatic sync_read(input string nm, input int hold, input logic [24:0] base,
                             input logic [24:0] addr, input logic [24:0] exp_addr,
                             input logic [7:0] dout);
        int n_early = 0;
        int cyc = 0;
        int cmd_cyc = -1;
        int vld_cyc = -1;
        logic [24:0] seen_addr = '0;
        model_dout   = dout;
        model_busy   = 2;
        bus.rd_req   = 1'b1;
        bus.img_base = base;
        bus.rd_addr  = addr;
        repeat (hold) begin
            @(negedge clk);
            if (bus.sd_rd || bus.sd_we) n_early++;
        end
        chk({nm, " no cmd in sync"}, 64'(n_early), 64'd0);
        model_stuck = 1'b0;
        while (vld_cyc < 0 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (bus.sd_rd && cmd_cyc < 0) begin
                cmd_cyc   = cyc;
                seen_addr = bus.sd_addr;
            end
            if (bus.rd_valid) vld_cyc = cyc;
        end
        chk({nm, " cmd cycle"}, 64'(cmd_cyc), 64'd3);
        chk({nm, " sd_addr"}, 64'(seen_addr), 64'(exp_addr));
        chk({nm, " valid cycle"}, 64'(vld_cyc), 64'd7);
        chk({nm, " rd_data"}, 64'(bus.rd_data), 64'(dout));
        bus.rd_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int we_cyc, ack_cyc, rd_cyc, vld_cyc, overlap, cyc;

        vecs[0] = '{1'b1, 25'h0000100, 25'h0000000, 8'hA5, 3, 25'h0000100, 8'hA5, 6};
        vecs[1] = '{1'b0, 25'h0000123, 25'h0010000, 8'h3C, 3, 25'h0010123, 8'h3C, 6};
        vecs[2] = '{1'b1, 25'h1FFFFFF, 25'h0000000, 8'h00, 1, 25'h1FFFFFF, 8'h00, 6};
        vecs[3] = '{1'b0, 25'h0001111, 25'h00ABCDE, 8'hC3, 5, 25'h00ACDEF, 8'hC3, 8};
        vecs[4] = '{1'b1, 25'h0123456, 25'h0000000, 8'h5A, 4, 25'h0123456, 8'h5A, 7};
        vecs[5] = '{1'b0, 25'h1000005, 25'h1000000, 8'h81, 0, 25'h0000005, 8'h81, 6};

        rst           = 1'b1;
        bus.dl_active = 1'b0;
        bus.wr_req    = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.rd_req    = 1'b0;
        bus.rd_addr   = '0;
        bus.img_base  = '0;
        bus.sd_dout   = '0;
        bus.sd_ready  = 1'b0;

        // Reset state, then SYNC hold-off while sd_ready is low.
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        sync_read("sync", 10, 25'h0000000, 25'h0000040, 25'h0000040, 8'h99);

        foreach (vecs[i]) do_txn($sformatf("vec%0d", i), vecs[i]);

        // Simultaneous write and read: write goes first, read only after wr_ack.
        @(negedge clk);
        model_busy   = 3;
        model_dout   = 8'h42;
        bus.wr_req   = 1'b1;
        bus.wr_addr  = 25'h0002000;
        bus.wr_data  = 8'h11;
        bus.rd_req   = 1'b1;
        bus.img_base = 25'h0000000;
        bus.rd_addr  = 25'h0000030;
        we_cyc = -1; ack_cyc = -1; rd_cyc = -1; vld_cyc = -1; overlap = 0; cyc = 0;
        while (vld_cyc < 0 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            bus.wr_req = 1'b0;
            if (bus.sd_we && we_cyc < 0) we_cyc = cyc;
            if (bus.wr_ack && ack_cyc < 0) ack_cyc = cyc;
            if (bus.sd_rd && rd_cyc < 0) rd_cyc = cyc;
            if (bus.sd_rd && bus.sd_we) overlap++;
            if (bus.rd_valid) vld_cyc = cyc;
        end
        bus.rd_req = 1'b0;
        chk("both sd_we cycle", 64'(we_cyc), 64'd2);
        chk("both wr_ack cycle", 64'(ack_cyc), 64'd6);
        chk("both sd_rd cycle", 64'(rd_cyc), 64'd8);
        chk("both rd_valid cycle", 64'(vld_cyc), 64'd12);
        chk("both overlap", 64'(overlap), 64'd0);
        chk("both rd_data", 64'(bus.rd_data), 64'h42);
        @(negedge clk);

        // sd_ready stuck low: forced completion at the timeout, sticky error.
        chk("timeout_err before", 64'(bus.timeout_err), 64'd0);
        model_stuck = 1'b1;
        @(negedge clk);
        do_txn("stuck", '{1'b0, 25'h0000077, 25'h0000100, 8'h77, 0, 25'h0000177, 8'h77, 67});
        chk("timeout_err set", 64'(bus.timeout_err), 64'd1);
        model_stuck = 1'b0;
        @(negedge clk);
        do_txn("after_to", '{1'b1, 25'h0000200, 25'h0000000, 8'h3E, 2, 25'h0000200, 8'h3E, 6});
        chk("timeout_err sticky", 64'(bus.timeout_err), 64'd1);

        // Async reset in the middle of a WAIT, then address wrap after SYNC.
        model_stuck = 1'b1;
        @(negedge clk);
        bus.rd_req   = 1'b1;
        bus.img_base = 25'h0000000;
        bus.rd_addr  = 25'h0000010;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        bus.rd_req = 1'b0;
        #1;
        chk_zero("async reset");
        @(negedge clk);
        rst = 1'b0;
        sync_read("wrap", 3, 25'h1FFFFFF, 25'h0000002, 25'h0000001, 8'h6E);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
